adaptive_threshold_ctrl: RTL
============================

Name: adaptive_threshold_ctrl

Overview:
- Top-level sequencer for the adaptive-thresholding pipeline.
- On a start pulse it runs the 3x3 box-filter pass, which writes the mean image into mean memory. It then runs its own threshold pass, which compares each source pixel with its local mean plus an offset and writes a binary image.
- It owns the single read port of the source image memory. The port is muxed between the box filter (FILTER phase) and its own threshold scanner (THRESH phase).

Parameters:
- WIDTH_BITS, 7, log2 of image width.
- HEIGHT_BITS, 7, log2 of image height.
- WIDTH, 2**WIDTH_BITS, image width in pixels.
- HEIGHT, 2**HEIGHT_BITS, image height in pixels.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- iStart  in  1  one-cycle start request; sampled only in IDLE.
- iOffset  in  8  threshold offset C, unsigned; latched when iStart is accepted.
- oBusy  out  1  high from the cycle after iStart is accepted until DONE.
- oDone  out  1  one-cycle pulse when the binary image is complete.
- oPhase  out  2  0 IDLE, 1 FILTER, 2 THRESH, 3 DONE/FLUSH.
- oBfReset  out  1  active-high reset to the box filter instance.
- iBfImageCol  in  WIDTH_BITS  box-filter read column request.
- iBfImageRow  in  HEIGHT_BITS  box-filter read row request.
- iBfFinished  in  1  box-filter completion flag (level).
- oImageCol  out  WIDTH_BITS  source image memory read column.
- oImageRow  out  HEIGHT_BITS  source image memory read row.
- iImageData  in  8  source pixel; combinational (same-cycle) read.
- oMeanCol  out  WIDTH_BITS  mean memory read column.
- oMeanRow  out  HEIGHT_BITS  mean memory read row.
- iMeanData  in  8  mean value; combinational read.
- oBinCol  out  WIDTH_BITS  binary memory write column.
- oBinRow  out  HEIGHT_BITS  binary memory write row.
- oBinData  out  8  0x00 or 0xFF.
- oBinWren  out  1  binary memory write enable.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, pos=0, offset=0, oBusy=0, oDone=0, oBinWren=0, oBinData=0, oBfReset=1. oPhase=0.
- Reset mid-operation aborts immediately. The filter is held in reset, no further writes occur, and the FSM restarts from IDLE.
- State IDLE:
  - oBfReset=1.
  - If iStart=1: latch iOffset, pos<=0, go to FILTER; oBusy=1 from the next cycle.
- State FILTER:
  - oBfReset=0, so the box filter runs from the first FILTER cycle. It was held in reset, so iBfFinished starts at 0.
  - The image port mux passes iBfImageCol/Row to oImageCol/Row.
  - When iBfFinished=1, go to THRESH with pos=0.
  - oBfReset returns to 1 on the same edge, freezing the filter and clearing its finished flag.
- State THRESH (1 pixel per cycle):
  - oImageCol/Row and oMeanCol/Row all equal pos (col = pos[WIDTH_BITS-1:0], row = upper bits).
  - Compare result: white iff ({1'b0,iImageData} + {1'b0,offset}) > {1'b0,iMeanData}. The sum is 9-bit, so there is no overflow.
  - Write pipeline, registered with latency 1: next cycle oBinWren=1, oBinCol/Row = previous pos, oBinData = white ? 0xFF : 0x00.
  - pos increments each cycle. When pos = WIDTH*HEIGHT-1, go to FLUSH.
- State FLUSH: exactly one cycle; the last write is visible. oBinWren is 0 in any cycle without a pending write.
- State DONE:
  - oDone=1 for exactly one cycle, and oBusy=0 in that same cycle.
  - Next state IDLE.
  - iStart in DONE is ignored.
- Arbitration: outside FILTER, oImageCol/Row come from pos. In IDLE and DONE, pos holds, so reads are harmless.
- Write count: exactly WIDTH*HEIGHT binary writes per run, in raster order, with no duplicates.
- iStart while busy: ignored, with no restart and no offset change. A mid-run change of iOffset has no effect.
- Run timing: THRESH is WIDTH*HEIGHT cycles; total run = filter time + WIDTH*HEIGHT + 3 cycles.

Test Plan:
- Reset sequence: assert reset=0 mid-THRESH on a 4x4 build (WIDTH_BITS=HEIGHT_BITS=2) -> outputs drop immediately to their reset values (oBfReset=1, oBinWren=0). After release, FSM is IDLE and oBusy=0.
- Uniform image: all pixels 100, iOffset=0, 4x4 -> means 100. All 16 writes are 0x00 (100 > 100 is false). oDone pulses once; exactly 16 oBinWren pulses, raster order.
- Offset boundary: same image with iOffset=1 -> all 16 writes 0xFF. With pixel=255 and offset=255 -> sum 510 > mean, giving 0xFF with no wrap.
- Single bright pixel: pixel (1,1)=90, others 0, iOffset=0 -> (1,1) mean 10, giving 0xFF. Neighbours have mean 10 vs 0, giving 0x00. Non-neighbours have 0 > 0 false, giving 0x00.
- Handshake: iStart held high for 5 cycles, and pulsed again during THRESH -> a single run and a single oDone. The offset latched at the first accept is used.
- Mux check: during FILTER, oImageCol/Row track iBfImageCol/Row every cycle. During THRESH, they equal oMeanCol/Row and follow the raster counter.

Source files
------------

// File: rtl/adaptive_threshold_ctrl_if.sv
// Control, box-filter and memory-port signals of the adaptive-threshold sequencer.
// The slave modport is the sequencer's view; master is the surrounding pipeline.
interface adaptive_threshold_ctrl_if #(
  parameter int WIDTH_BITS  = 7,
  parameter int HEIGHT_BITS = 7
);
  logic                   iStart;
  logic [7:0]             iOffset;
  logic                   oBusy;
  logic                   oDone;
  logic [1:0]             oPhase;
  logic                   oBfReset;
  logic [WIDTH_BITS-1:0]  iBfImageCol;
  logic [HEIGHT_BITS-1:0] iBfImageRow;
  logic                   iBfFinished;
  logic [WIDTH_BITS-1:0]  oImageCol;
  logic [HEIGHT_BITS-1:0] oImageRow;
  logic [7:0]             iImageData;
  logic [WIDTH_BITS-1:0]  oMeanCol;
  logic [HEIGHT_BITS-1:0] oMeanRow;
  logic [7:0]             iMeanData;
  logic [WIDTH_BITS-1:0]  oBinCol;
  logic [HEIGHT_BITS-1:0] oBinRow;
  logic [7:0]             oBinData;
  logic                   oBinWren;

  modport slave (
    input  iStart, iOffset, iBfImageCol, iBfImageRow, iBfFinished, iImageData, iMeanData,
    output oBusy, oDone, oPhase, oBfReset, oImageCol, oImageRow, oMeanCol, oMeanRow,
           oBinCol, oBinRow, oBinData, oBinWren
  );

  modport master (
    output iStart, iOffset, iBfImageCol, iBfImageRow, iBfFinished, iImageData, iMeanData,
    input  oBusy, oDone, oPhase, oBfReset, oImageCol, oImageRow, oMeanCol, oMeanRow,
           oBinCol, oBinRow, oBinData, oBinWren
  );
endinterface

// File: rtl/adaptive_threshold_ctrl.sv
// Sequencer for adaptive thresholding: runs the box filter, then a raster threshold pass
// writing 0x00/0xFF per pixel from (pixel + offset) > local mean.
module adaptive_threshold_ctrl #(
  parameter int WIDTH_BITS  = 7,
  parameter int HEIGHT_BITS = 7,
  parameter int WIDTH       = 2**WIDTH_BITS,
  parameter int HEIGHT      = 2**HEIGHT_BITS
) (
  input  logic                      clock,
  input  logic                      reset,
  adaptive_threshold_ctrl_if.slave  bus
);
  localparam int POS_BITS = WIDTH_BITS + HEIGHT_BITS;
  localparam logic [POS_BITS-1:0] LAST_POS = POS_BITS'(WIDTH * HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILTER,
    S_THRESH,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [POS_BITS-1:0] pos_q;
  logic [7:0]          offset_q;
  logic                busy_q;
  logic                done_q;
  logic                bf_reset_q;
  logic [1:0]          phase_q;
  logic                wren_q;
  logic [7:0]          bin_data_q;
  logic [POS_BITS-1:0] bin_pos_q;

  // Nine-bit sum so a bright pixel plus a large offset cannot wrap below the mean.
  logic [8:0] sum_d;
  logic       white_d;
  assign sum_d   = {1'b0, bus.iImageData} + {1'b0, offset_q};
  assign white_d = sum_d > {1'b0, bus.iMeanData};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pos_q      <= '0;
      offset_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bf_reset_q <= 1'b1;
      phase_q    <= 2'd0;
      wren_q     <= 1'b0;
      bin_data_q <= '0;
      bin_pos_q  <= '0;
    end else begin
      done_q <= 1'b0;
      wren_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.iStart) begin
            offset_q   <= bus.iOffset;
            pos_q      <= '0;
            busy_q     <= 1'b1;
            bf_reset_q <= 1'b0;
            phase_q    <= 2'd1;
            state_q    <= S_FILTER;
          end
        end
        S_FILTER: begin
          if (bus.iBfFinished) begin
            pos_q      <= '0;
            bf_reset_q <= 1'b1;
            phase_q    <= 2'd2;
            state_q    <= S_THRESH;
          end
        end
        S_THRESH: begin
          wren_q     <= 1'b1;
          bin_pos_q  <= pos_q;
          bin_data_q <= white_d ? 8'hFF : 8'h00;
          pos_q      <= pos_q + 1'b1;
          if (pos_q == LAST_POS) begin
            phase_q <= 2'd3;
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          phase_q <= 2'd0;
          state_q <= S_IDLE;
        end
        default: begin
          phase_q <= 2'd0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The box filter owns the source port only while it is running.
  assign bus.oImageCol = (state_q == S_FILTER) ? bus.iBfImageCol : pos_q[WIDTH_BITS-1:0];
  assign bus.oImageRow = (state_q == S_FILTER) ? bus.iBfImageRow : pos_q[POS_BITS-1:WIDTH_BITS];
  assign bus.oMeanCol  = pos_q[WIDTH_BITS-1:0];
  assign bus.oMeanRow  = pos_q[POS_BITS-1:WIDTH_BITS];

  assign bus.oBusy    = busy_q;
  assign bus.oDone    = done_q;
  assign bus.oPhase   = phase_q;
  assign bus.oBfReset = bf_reset_q;
  assign bus.oBinWren = wren_q;
  assign bus.oBinData = bin_data_q;
  assign bus.oBinCol  = bin_pos_q[WIDTH_BITS-1:0];
  assign bus.oBinRow  = bin_pos_q[POS_BITS-1:WIDTH_BITS];
endmodule
